// File: rtl/dso_pkg.sv
// dso_pkg: constants and the reader state encoding shared by the capture and read sides of the DSO buffer
package dso_pkg;
    localparam int BANK_DEPTH = 2048;
    localparam int BANK_AW    = 11;
    localparam int HDR_BYTES  = 3;
    localparam int ST_READY   = 0;
    localparam int ST_TRIG    = 1;
    localparam logic [7:0] PAD_BYTE = 8'h00;
    localparam logic [11:0] N_FIRST_SMP = 12'(HDR_BYTES);
    localparam logic [11:0] N_LAST_SMP  = 12'(HDR_BYTES + BANK_DEPTH - 1);
    localparam logic [11:0] N_PAD       = 12'(HDR_BYTES + BANK_DEPTH);
    typedef enum logic [1:0] {RD_IDLE, RD_HDR, RD_STREAM, RD_PAD} rd_state_t;
endpackage

// File: rtl/adc_buffer_reader.sv
// adc_buffer_reader: SPI read side of the ping-pong sample buffer, streams a 3-byte header then one bank oldest-first
// Ports:
//   clk, rst_n                       system clock, synchronous active-low reset
//   update_flag, trigger_flag        capture-side pulses qualifying write_addr
//   write_addr[11:0]                 capture write address {bank, offset}
//   triggered                        capture status, reported in the status byte
//   sel, reset_flag, valid_flag      SPI slave select, transaction start, byte consumed
//   so[DATA_W-1:0]                   byte presented to the SPI shifter
//   addr[11:0], data[DATA_W-1:0]     buffer memory read port (1-cycle latency)
module adc_buffer_reader
    import dso_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update_flag,
    input  logic              trigger_flag,
    input  logic [11:0]       write_addr,
    input  logic              triggered,
    input  logic              sel,
    input  logic              reset_flag,
    input  logic              valid_flag,
    output logic [DATA_W-1:0] so,
    output logic [11:0]       addr,
    input  logic [DATA_W-1:0] data
);
    rd_state_t          r_state, w_state_nxt;
    logic [11:0]        r_n;
    logic               r_p_bank, r_p_ready, r_bank;
    logic [BANK_AW-1:0] r_p_start, r_p_trig_idx, r_trig_off, r_start, r_trig_idx;
    logic [DATA_W-1:0]  r_sample, r_so;
    logic [11:0]        r_addr;
    logic               r_rd0, r_rd1;
    logic               w_start_tx, w_consume, w_adv;
    logic [11:0]        w_m;
    logic [BANK_AW-1:0] w_off;
    logic [DATA_W-1:0]  w_byte, w_status;

    assign so   = r_so;
    assign addr = r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RD_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = !sel ? RD_IDLE :
                      reset_flag ? RD_HDR :
                      (valid_flag && r_state == RD_HDR && r_n == 12'd2) ? RD_STREAM :
                      (valid_flag && r_state == RD_STREAM && r_n == N_LAST_SMP) ? RD_PAD :
                      r_state;
    end

    always_comb begin
        w_start_tx = sel && reset_flag;
        w_consume  = sel && !reset_flag && valid_flag && r_state != RD_IDLE;
        w_m        = r_n + 12'd1;
        // The sample now going onto so was prefetched; fetch the one after it, stopping at the last sample.
        w_adv      = w_consume && w_m >= N_FIRST_SMP && w_m < N_LAST_SMP;
        w_off      = r_start + w_m[BANK_AW-1:0] - 11'd2;
        w_status   = '0;
        w_status[ST_READY] = r_p_ready;
        w_status[ST_TRIG]  = triggered;
        w_byte     = (w_m == 12'd1) ? {5'b0, r_trig_idx[10:8]} :
                     (w_m == 12'd2) ? r_trig_idx[7:0] :
                     (w_m <= N_LAST_SMP) ? r_sample : PAD_BYTE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_so       <= '0;
            r_addr     <= '0;
            r_rd0      <= 1'b0;
            r_rd1      <= 1'b0;
            r_sample   <= '0;
            r_p_bank   <= 1'b0;
            r_p_start  <= '0;
            r_p_trig_idx <= '0;
            r_p_ready  <= 1'b0;
            r_trig_off <= '0;
            r_bank     <= 1'b0;
            r_start    <= '0;
            r_trig_idx <= '0;
        end else begin
            r_n    <= (!sel || reset_flag) ? '0 : (w_consume && r_n != N_PAD) ? w_m : r_n;
            r_so   <= !sel ? PAD_BYTE : w_start_tx ? w_status : w_consume ? w_byte : r_so;
            r_addr <= w_start_tx ? {r_p_bank, r_p_start} : w_adv ? {r_bank, w_off} : r_addr;
            // Two-stage tag follows each issued read through the memory latency into the prefetch register.
            r_rd0  <= w_start_tx || w_adv;
            r_rd1  <= r_rd0;
            if (r_rd1) r_sample <= data;
            if (trigger_flag) r_trig_off <= write_addr[BANK_AW-1:0];
            // Uses the trigger offset held before this cycle, so a coincident trigger belongs to the next capture.
            if (update_flag) begin
                r_p_bank     <= write_addr[11];
                r_p_start    <= write_addr[BANK_AW-1:0];
                r_p_trig_idx <= r_trig_off - write_addr[BANK_AW-1:0];
                r_p_ready    <= 1'b1;
            end else if (w_start_tx) begin
                r_p_ready    <= 1'b0;
            end
            if (w_start_tx) begin
                r_bank     <= r_p_bank;
                r_start    <= r_p_start;
                r_trig_idx <= r_p_trig_idx;
            end
        end
    end
endmodule

// File: tb/tb_adc_buffer_reader.sv
// tb_adc_buffer_reader: directed self-checking bench for adc_buffer_reader with a 1-cycle-latency memory returning addr[7:0]
module tb_adc_buffer_reader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        update_flag = 0, trigger_flag = 0, triggered = 0;
    logic        sel = 0, reset_flag = 0, valid_flag = 0;
    logic [11:0] write_addr = 0;
    logic [7:0]  so, data = 0;
    logic [11:0] addr;
    int          errs = 0, checks = 0;
    logic        log_en = 0;
    logic [11:0] alog[$];

    typedef enum int {OP_SEL1, OP_SEL0, OP_RST, OP_VAL, OP_TRIG, OP_UPD} op_t;
    typedef struct {
        op_t         op;
        logic [11:0] wa;
        logic [7:0]  so;
        bit          ca;
        logic [11:0] ad;
    } vec_t;
    vec_t tbl[$];

    adc_buffer_reader #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .update_flag(update_flag), .trigger_flag(trigger_flag),
        .write_addr(write_addr), .triggered(triggered), .sel(sel), .reset_flag(reset_flag),
        .valid_flag(valid_flag), .so(so), .addr(addr), .data(data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) data <= addr[7:0];
    always @(negedge clk)
        if (log_en && (alog.size() == 0 || alog[alog.size()-1] != addr)) alog.push_back(addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
    endtask

    task automatic do_sel(input logic v);
        @(posedge clk); #1 sel = v;
        @(posedge clk); #1;
        if (!v) chk("sel0_so", so, 8'h00);
    endtask

    task automatic do_rst(input logic [7:0] exp_so, input logic [11:0] exp_ad);
        @(posedge clk); #1 reset_flag = 1;
        @(posedge clk); #1 reset_flag = 0;
        chk("status", so, exp_so);
        chk("start_addr", addr, exp_ad);
        gap();
    endtask

    task automatic do_val(input string nm, input logic [7:0] exp_so);
        @(posedge clk); #1 valid_flag = 1;
        @(posedge clk); #1 valid_flag = 0;
        chk(nm, so, exp_so);
        gap();
    endtask

    task automatic do_cap(input bit upd, input logic [11:0] wa);
        @(posedge clk); #1 write_addr = wa; update_flag = upd; trigger_flag = !upd;
        @(posedge clk); #1 update_flag = 0; trigger_flag = 0;
    endtask

    initial begin
        tbl.push_back('{OP_SEL1, 12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_RST,  12'h000, 8'h00, 1'b1, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_SEL0, 12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_TRIG, 12'h3FF, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_UPD,  12'h800, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_SEL1, 12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_RST,  12'h000, 8'h01, 1'b1, 12'h800});
        tbl.push_back('{OP_VAL,  12'h000, 8'h03, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'hFF, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h00, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h01, 1'b0, 12'h000});
        tbl.push_back('{OP_VAL,  12'h000, 8'h02, 1'b0, 12'h000});
        tbl.push_back('{OP_RST,  12'h000, 8'h00, 1'b1, 12'h800});
        tbl.push_back('{OP_SEL0, 12'h000, 8'h00, 1'b0, 12'h000});

        repeat (3) @(posedge clk);
        #1 chk("rst_so", so, 8'h00);
        chk("rst_addr", addr, 12'h000);
        rst_n = 1;
        @(posedge clk); #1;
        do_val("idle_val", 8'h00);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_SEL1: do_sel(1'b1);
                OP_SEL0: do_sel(1'b0);
                OP_RST:  do_rst(tbl[i].so, tbl[i].ad);
                OP_VAL:  do_val("tbl_byte", tbl[i].so);
                OP_TRIG: do_cap(1'b0, tbl[i].wa);
                default: do_cap(1'b1, tbl[i].wa);
            endcase
        end

        // Wrap and full read: start 0x7FE, trig_idx = (0x3FF - 0x7FE) mod 2048 = 0x401.
        do_cap(1'b1, 12'h7FE);
        do_sel(1'b1);
        do_rst(8'h01, 12'h7FE);
        log_en = 1;
        do_val("hdr1", 8'h04);
        do_val("hdr2", 8'h01);
        for (int k = 0; k < 2048; k++) begin
            do_val("sample", 8'((12'h7FE + k) & 12'hFF));
            if (k == 4) log_en = 0;
        end
        chk("alog_len_ok", 32'(alog.size() >= 4), 32'd1);
        if (alog.size() >= 4) begin
            chk("wrap_a0", alog[0], 12'h7FE);
            chk("wrap_a1", alog[1], 12'h7FF);
            chk("wrap_a2", alog[2], 12'h000);
            chk("wrap_a3", alog[3], 12'h001);
        end
        chk("last_addr", addr, 12'h7FD);
        do_val("pad1", 8'h00);
        do_val("pad2", 8'h00);
        chk("frozen_addr", addr, 12'h7FD);
        do_sel(1'b0);

        // Capture arriving mid-stream only affects the following transaction.
        do_sel(1'b1);
        do_rst(8'h00, 12'h7FE);
        do_val("m_hdr1", 8'h04);
        do_val("m_hdr2", 8'h01);
        do_val("m_s0", 8'hFE);
        do_cap(1'b1, 12'h805);
        do_val("m_s1", 8'hFF);
        do_val("m_s2", 8'h00);
        do_sel(1'b0);
        do_sel(1'b1);
        do_rst(8'h01, 12'h805);
        do_val("n_hdr1", 8'h03);
        do_val("n_hdr2", 8'hFA);
        do_val("n_s0", 8'h05);
        do_sel(1'b0);
        do_sel(1'b1);
        do_rst(8'h00, 12'h805);

        // Drop sel after byte 10, restart, then assert reset mid-stream.
        for (int b = 1; b <= 10; b++) do_val("pre_drop", (b == 1) ? 8'h03 : (b == 2) ? 8'hFA : 8'(b + 2));
        do_sel(1'b0);
        triggered = 1;
        do_sel(1'b1);
        do_rst(8'h02, 12'h805);
        do_val("r_hdr1", 8'h03);
        do_val("r_hdr2", 8'hFA);
        do_val("r_s0", 8'h05);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        chk("rstn_so", so, 8'h00);
        chk("rstn_addr", addr, 12'h000);
        rst_n = 1;
        triggered = 0;
        sel = 0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
